// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline hazard and sequencing controller for the 5-stage RV32IM core
// (IF -> ifu_de -> de -> de_alu/EX -> LSU). Every cycle it decides whether
// each pipeline register advances, holds, or loads a bubble. It handles:
//   - load-use interlocks (one-cycle bubble into EX),
//   - taken jump/branch redirects (flush of the two younger stages),
//   - multi-cycle EX operations such as the divider, with a timeout abort,
//   - debug halt with a fixed drain period before reporting quiescence.
// It also keeps two free-running performance counters.
//
// Ports
//   clk, rst_n        core clock; asynchronous active-low reset
//   de_rd_reg1_flag   DE reads rs1          de_rd_addr1 [4:0]  rs1 index
//   de_rd_reg2_flag   DE reads rs2          de_rd_addr2 [4:0]  rs2 index
//   ex_is_load        EX holds a load       ex_wr_reg_en       EX writes RF
//   ex_wr_reg_addr    [4:0] EX destination register
//   jump_flag         EX resolved a taken redirect; jump_addr [31:0] target
//   mc_start          one-cycle pulse: EX issues a multi-cycle op
//   mc_done           multi-cycle result valid this cycle
//   halt_req          debug halt request (level)
//   perf_clr          synchronous clear of both performance counters
//   hold_pc / hold_if_de / hold_de_ex      stage register keeps its value
//   flush_if_de / flush_de_ex              stage register loads a NOP
//   bubble_ex_lsu     EX->LSU register loads a NOP
//   pc_load           PC loads pc_load_addr (= jump_addr)
//   halted            core is quiescent
//   mc_err            one-cycle pulse on multi-cycle timeout
//   stall_cnt [31:0]  cycles with hold_pc asserted
//   flush_cnt [31:0]  taken redirects (cycles with pc_load asserted)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned MC_TIMEOUT   = 64,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_rd_reg1_flag,
  input  logic [4:0]  de_rd_addr1,
  input  logic        de_rd_reg2_flag,
  input  logic [4:0]  de_rd_addr2,
  input  logic        ex_is_load,
  input  logic        ex_wr_reg_en,
  input  logic [4:0]  ex_wr_reg_addr,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  input  logic        mc_start,
  input  logic        mc_done,
  input  logic        halt_req,
  input  logic        perf_clr,
  output logic        hold_pc,
  output logic        hold_if_de,
  output logic        hold_de_ex,
  output logic        flush_if_de,
  output logic        flush_de_ex,
  output logic        bubble_ex_lsu,
  output logic        pc_load,
  output logic [31:0] pc_load_addr,
  output logic        halted,
  output logic        mc_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_HALTING = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  // One counter serves both the multi-cycle timeout and the halt drain,
  // since the two states are mutually exclusive.
  localparam int unsigned         CNT_W        = 16;
  localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;
  logic [31:0]        flush_cnt_q, flush_cnt_d;

  logic lu_s;
  logic hold_pc_s, hold_if_de_s, hold_de_ex_s;
  logic flush_if_de_s, flush_de_ex_s, bubble_ex_lsu_s;
  logic pc_load_s, halted_s, mc_err_s;

  // Load-use: a load in EX writes a non-zero register that DE reads.
  assign lu_s = ex_is_load && ex_wr_reg_en && (ex_wr_reg_addr != 5'd0) &&
                ((de_rd_reg1_flag && (de_rd_addr1 == ex_wr_reg_addr)) ||
                 (de_rd_reg2_flag && (de_rd_addr2 == ex_wr_reg_addr)));

  // Next-state and control-output decode.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    hold_pc_s       = 1'b0;
    hold_if_de_s    = 1'b0;
    hold_de_ex_s    = 1'b0;
    flush_if_de_s   = 1'b0;
    flush_de_ex_s   = 1'b0;
    bubble_ex_lsu_s = 1'b0;
    pc_load_s       = 1'b0;
    halted_s        = 1'b0;
    mc_err_s        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (jump_flag) begin
          // Redirect wins; a simultaneous mc_start belongs to a squashed path.
          pc_load_s     = 1'b1;
          flush_if_de_s = 1'b1;
          flush_de_ex_s = 1'b1;
        end else if (mc_start) begin
          hold_pc_s       = 1'b1;
          hold_if_de_s    = 1'b1;
          hold_de_ex_s    = 1'b1;
          bubble_ex_lsu_s = 1'b1;
          state_d         = ST_MC_BUSY;
          cnt_d           = {CNT_W{1'b0}};
        end else if (lu_s) begin
          // Single bubble; the LSU bypass supplies the operand next cycle.
          hold_pc_s     = 1'b1;
          hold_if_de_s  = 1'b1;
          flush_de_ex_s = 1'b1;
        end else if (halt_req) begin
          hold_pc_s     = 1'b1;
          hold_if_de_s  = 1'b1;
          flush_de_ex_s = 1'b1;
          state_d       = ST_HALTING;
          cnt_d         = {CNT_W{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MC_BUSY: begin
        if (mc_done) begin
          // Everything released so the result advances this cycle.
          state_d = ST_RUN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Abort: drop the stuck op from EX and resume fetching.
          mc_err_s      = 1'b1;
          flush_de_ex_s = 1'b1;
          state_d       = ST_RUN;
        end else begin
          hold_pc_s       = 1'b1;
          hold_if_de_s    = 1'b1;
          hold_de_ex_s    = 1'b1;
          bubble_ex_lsu_s = 1'b1;
          cnt_d           = cnt_q + CNT_W'(1);
        end
      end
      ST_HALTING: begin
        hold_pc_s     = 1'b1;
        hold_if_de_s  = 1'b1;
        flush_de_ex_s = 1'b1;
        // An older instruction still draining out of EX may redirect.
        if (jump_flag) begin
          pc_load_s     = 1'b1;
          flush_if_de_s = 1'b1;
        end else begin
          pc_load_s     = 1'b0;
          flush_if_de_s = 1'b0;
        end
        if (!halt_req) begin
          state_d = ST_RUN;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HALTED: begin
        halted_s      = 1'b1;
        hold_pc_s     = 1'b1;
        hold_if_de_s  = 1'b1;
        flush_de_ex_s = 1'b1;
        if (!halt_req) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Performance counter next values; clear has priority over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = 32'd0;
      flush_cnt_d = 32'd0;
    end else begin
      if (hold_pc_s) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (pc_load_s) begin
        flush_cnt_d = flush_cnt_q + 32'd1;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State, sequencing counter and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= {CNT_W{1'b0}};
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are combinational but must read 0 the moment reset asserts,
  // independent of whatever the inputs are doing.
  assign hold_pc       = hold_pc_s       & rst_n;
  assign hold_if_de    = hold_if_de_s    & rst_n;
  assign hold_de_ex    = hold_de_ex_s    & rst_n;
  assign flush_if_de   = flush_if_de_s   & rst_n;
  assign flush_de_ex   = flush_de_ex_s   & rst_n;
  assign bubble_ex_lsu = bubble_ex_lsu_s & rst_n;
  assign pc_load       = pc_load_s       & rst_n;
  assign halted        = halted_s        & rst_n;
  assign mc_err        = mc_err_s        & rst_n;
  assign pc_load_addr  = rst_n ? jump_addr : 32'd0;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed self-checking bench for pipe_ctrl (MC_TIMEOUT=64, DRAIN_CYCLES=3).
// Inputs change 1 time unit after the rising edge; combinational controls are
// checked 2 units later, registered counters just after the edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de_rd_reg1_flag, de_rd_reg2_flag;
  logic [4:0]  de_rd_addr1, de_rd_addr2;
  logic        ex_is_load, ex_wr_reg_en;
  logic [4:0]  ex_wr_reg_addr;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        mc_start, mc_done, halt_req, perf_clr;
  logic        hold_pc, hold_if_de, hold_de_ex, flush_if_de, flush_de_ex;
  logic        bubble_ex_lsu, pc_load, halted, mc_err;
  logic [31:0] pc_load_addr, stall_cnt, flush_cnt;

  int total  = 0;
  int passes = 0;

  // Expected control words: {hpc,hif,hde,fif,fde,bub,pcl,hlt,err}
  localparam logic [8:0] C_HPC = 9'h100;
  localparam logic [8:0] C_HIF = 9'h080;
  localparam logic [8:0] C_HDE = 9'h040;
  localparam logic [8:0] C_FIF = 9'h020;
  localparam logic [8:0] C_FDE = 9'h010;
  localparam logic [8:0] C_BUB = 9'h008;
  localparam logic [8:0] C_PCL = 9'h004;
  localparam logic [8:0] C_HLT = 9'h002;
  localparam logic [8:0] C_ERR = 9'h001;
  localparam logic [8:0] C_NONE  = 9'h000;
  localparam logic [8:0] C_LU    = C_HPC | C_HIF | C_FDE;
  localparam logic [8:0] C_JUMP  = C_FIF | C_FDE | C_PCL;
  localparam logic [8:0] C_MC    = C_HPC | C_HIF | C_HDE | C_BUB;
  localparam logic [8:0] C_HALTG = C_HPC | C_HIF | C_FDE;

  logic [8:0] ctl;
  assign ctl = {hold_pc, hold_if_de, hold_de_ex, flush_if_de, flush_de_ex,
                bubble_ex_lsu, pc_load, halted, mc_err};

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_TIMEOUT(64), .DRAIN_CYCLES(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .de_rd_reg1_flag (de_rd_reg1_flag),
    .de_rd_addr1     (de_rd_addr1),
    .de_rd_reg2_flag (de_rd_reg2_flag),
    .de_rd_addr2     (de_rd_addr2),
    .ex_is_load      (ex_is_load),
    .ex_wr_reg_en    (ex_wr_reg_en),
    .ex_wr_reg_addr  (ex_wr_reg_addr),
    .jump_flag       (jump_flag),
    .jump_addr       (jump_addr),
    .mc_start        (mc_start),
    .mc_done         (mc_done),
    .halt_req        (halt_req),
    .perf_clr        (perf_clr),
    .hold_pc         (hold_pc),
    .hold_if_de      (hold_if_de),
    .hold_de_ex      (hold_de_ex),
    .flush_if_de     (flush_if_de),
    .flush_de_ex     (flush_de_ex),
    .bubble_ex_lsu   (bubble_ex_lsu),
    .pc_load         (pc_load),
    .pc_load_addr    (pc_load_addr),
    .halted          (halted),
    .mc_err          (mc_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkctl(input string tag, input logic [8:0] exp);
    #2;
    chk(tag, {23'd0, ctl}, {23'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    de_rd_reg1_flag = 1'b0; de_rd_addr1 = 5'd0;
    de_rd_reg2_flag = 1'b0; de_rd_addr2 = 5'd0;
    ex_is_load = 1'b0; ex_wr_reg_en = 1'b0; ex_wr_reg_addr = 5'd0;
    jump_flag = 1'b0; jump_addr = 32'd0;
    mc_start = 1'b0; mc_done = 1'b0; halt_req = 1'b0; perf_clr = 1'b0;
  endtask

  // LW x5 in EX, ADD x6,x5,x1 in DE
  task automatic set_lu();
    ex_is_load = 1'b1; ex_wr_reg_en = 1'b1; ex_wr_reg_addr = 5'd5;
    de_rd_reg1_flag = 1'b1; de_rd_addr1 = 5'd5;
    de_rd_reg2_flag = 1'b1; de_rd_addr2 = 5'd1;
  endtask

  initial begin
    // ---------------- reset ----------------
    rst_n = 1'b0;
    idle();
    jump_flag = 1'b1; jump_addr = 32'h0000_1234; mc_start = 1'b1;
    chkctl("reset_ctl", C_NONE);
    chk("reset_pc_load_addr", pc_load_addr, 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_flush_cnt", flush_cnt, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    idle();

    // ---------------- load-use ----------------
    set_lu();
    chkctl("lu_rs1", C_LU);
    tick();
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    ex_is_load = 1'b0; ex_wr_reg_en = 1'b0;     // bubble now in EX
    chkctl("lu_resolved", C_NONE);
    tick();
    ex_is_load = 1'b1; ex_wr_reg_en = 1'b1; ex_wr_reg_addr = 5'd0;
    de_rd_addr1 = 5'd0; de_rd_addr2 = 5'd0;
    chkctl("lu_rd_x0", C_NONE);
    tick();
    chk("lu_x0_stall_cnt", stall_cnt, 32'd1);
    ex_wr_reg_addr = 5'd7;
    de_rd_reg1_flag = 1'b0; de_rd_addr1 = 5'd3;
    de_rd_reg2_flag = 1'b1; de_rd_addr2 = 5'd7;
    chkctl("lu_rs2", C_LU);
    tick();
    chk("lu_rs2_stall_cnt", stall_cnt, 32'd2);
    de_rd_reg2_flag = 1'b0;
    chkctl("lu_rs2_not_read", C_NONE);
    tick();

    // ---------------- jump ----------------
    set_lu();
    jump_flag = 1'b1; jump_addr = 32'h8000_0100;
    chkctl("jump_over_lu", C_JUMP);
    chk("jump_pc_load_addr", pc_load_addr, 32'h8000_0100);
    tick();
    chk("jump_flush_cnt", flush_cnt, 32'd1);
    chk("jump_stall_cnt", stall_cnt, 32'd2);
    idle();
    jump_flag = 1'b1; jump_addr = 32'h0000_0040; mc_start = 1'b1;
    chkctl("jump_over_mc_start", C_JUMP);
    tick();
    idle();
    perf_clr = 1'b1;
    chkctl("no_mc_after_jump", C_NONE);
    tick();
    chk("perf_clr_stall", stall_cnt, 32'd0);
    chk("perf_clr_flush", flush_cnt, 32'd0);
    perf_clr = 1'b0;

    // ---------------- multi-cycle, done after 33 ----------------
    mc_start = 1'b1;
    chkctl("mc_start", C_MC);
    tick();
    mc_start = 1'b0;
    for (int k = 1; k < 33; k++) begin
      chkctl("mc_busy_hold", C_MC);
      tick();
    end
    mc_done = 1'b1;
    chkctl("mc_done_release", C_NONE);
    tick();
    mc_done = 1'b0;
    chk("mc_stall_cnt", stall_cnt, 32'd33);
    chkctl("mc_run_after_done", C_NONE);
    tick();

    // ---------------- multi-cycle timeout ----------------
    mc_start = 1'b1;
    chkctl("mc_to_start", C_MC);
    tick();
    mc_start = 1'b0;
    for (int k = 1; k < 64; k++) begin
      chkctl("mc_to_busy", C_MC);
      tick();
    end
    chkctl("mc_timeout", C_FDE | C_ERR);
    tick();
    chkctl("mc_run_after_timeout", C_NONE);
    tick();
    chk("mc_to_stall_cnt", stall_cnt, 32'd97);

    // ---------------- halt ----------------
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    halt_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        jump_flag = 1'b1; jump_addr = 32'h0000_2000;
        chkctl("halting_jump", C_HALTG | C_FIF | C_PCL);
        chk("halting_jump_addr", pc_load_addr, 32'h0000_2000);
      end else if (i < 4) begin
        jump_flag = 1'b0;
        chkctl("halting", C_HALTG);
      end else begin
        jump_flag = 1'b0;
        chkctl("halted", C_HALTG | C_HLT);
      end
      tick();
    end
    halt_req = 1'b0;
    chkctl("halted_release_cycle", C_HALTG | C_HLT);
    tick();
    chkctl("run_after_halt", C_NONE);
    chk("halt_stall_cnt", stall_cnt, 32'd7);
    chk("halt_flush_cnt", flush_cnt, 32'd1);
    tick();
    halt_req = 1'b1;
    chkctl("halt_req_run", C_HALTG);
    tick();
    chkctl("halting_again", C_HALTG);
    tick();
    halt_req = 1'b0;
    chkctl("halting_drop", C_HALTG);
    tick();
    for (int i = 0; i < 4; i++) begin
      chkctl("no_halted_after_drop", C_NONE);
      tick();
    end

    // ---------------- reset mid-MC_BUSY ----------------
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    mc_start = 1'b1;
    tick();
    mc_start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("mc_stall_before_reset", stall_cnt, 32'd10);
    #1 rst_n = 1'b0;
    #1 chk("reset_mid_mc_ctl", {23'd0, ctl}, 32'd0);
    chk("reset_mid_mc_stall", stall_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    set_lu();
    chkctl("run_after_reset", C_LU);
    tick();
    chk("stall_after_reset", stall_cnt, 32'd1);
    perf_clr = 1'b1;
    chkctl("lu_with_perf_clr", C_LU);
    tick();
    chk("perf_clr_priority", stall_cnt, 32'd0);
    idle();
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
